uart_tx_fifo: RTL and testbench

//   Transmit buffer between the LSU store path and the UART register block. Software pushes

---
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Transmit buffer between the LSU store path and the UART register block.
//   Bytes pushed by software are queued in a circular buffer. A drain FSM
//   sends each byte as two UART register writes, first data and then
//   control/start. It then waits for the UART frame-done pulse before it
//   takes the next byte.
//
// Ports
//   clk          rising-edge system clock
//   rst          synchronous reset, active-high
//   push         single-cycle strobe: enqueue push_data
//   push_data    byte to enqueue
//   ovf_clr      clears the sticky overflow flag
//   tx_complete  one-cycle UART frame-done pulse
//   u_wr_en      UART register write strobe (one cycle per write)
//   u_addr       UART register address (holds while u_wr_en is low)
//   u_wdata      UART register write data (holds while u_wr_en is low)
//   full         count == DEPTH
//   empty        count == 0
//   count        exact FIFO occupancy
//   overflow     sticky: a push was attempted while full
//   fifo_low     count <= THRESH (level interrupt source)
//   busy         drain FSM is not idle
module uart_tx_fifo #(
   parameter int          DEPTH      = 8,
   parameter logic [31:0] UDATA_ADDR = 32'h0000_0000,
   parameter logic [31:0] UCTR_ADDR  = 32'h0000_0008,
   parameter logic [31:0] CTR_START  = 32'h0000_0001,
   parameter int          THRESH     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     ovf_clr,
   input  logic                     tx_complete,
   output logic                     u_wr_en,
   output logic [31:0]              u_addr,
   output logic [31:0]              u_wdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     fifo_low,
   output logic                     busy
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LOW_LVL  = (AW+1)'(THRESH);

   typedef enum logic [1:0] {IDLE, WR_DATA, WR_CTRL, WAIT_DONE} state_t;

   state_t         state;
   state_t         state_next;
   logic [7:0]     mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           pop;
   logic           accept;
   logic           drop;
   logic           wr_en_d;
   logic [31:0]    addr_d;
   logic [31:0]    wdata_d;

   // The head leaves the FIFO in the same cycle its data write is on the bus.
   // A push while full still fits when that pop frees a slot at the same edge.
   assign pop    = (state == WR_DATA);
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;

   assign full     = (count == FULL_LVL);
   assign empty    = (count == '0);
   assign fifo_low = (count <= LOW_LVL);
   assign busy     = (state != IDLE);

   // FIFO control: pointers, exact occupancy, sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A new overflow takes priority over a clear in the same cycle
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   // Storage is plain data and needs no reset; count alone decides validity
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= push_data;
   end

   // Drain FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Drain FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (!empty) state_next = WR_DATA;
         WR_DATA:   state_next = WR_CTRL;
         WR_CTRL:   state_next = WAIT_DONE;
         WAIT_DONE: if (tx_complete) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Drain FSM: outputs are decoded from the next state and then registered.
   // As a result, the bus write appears in the same cycle as the state that
   // issues it.
   always_comb begin
      wr_en_d = 1'b0;
      addr_d  = u_addr;
      wdata_d = u_wdata;
      case (state_next)
         WR_DATA: begin
            wr_en_d = 1'b1;
            addr_d  = UDATA_ADDR;
            wdata_d = {24'b0, mem[rd_ptr]};
         end
         WR_CTRL: begin
            wr_en_d = 1'b1;
            addr_d  = UCTR_ADDR;
            wdata_d = CTR_START;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         u_wr_en <= 1'b0;
         u_addr  <= '0;
         u_wdata <= '0;
      end else begin
         u_wr_en <= wr_en_d;
         u_addr  <= addr_d;
         u_wdata <= wdata_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. A negedge monitor logs every UART write
//   (address, data, cycle). The main sequence drives pushes and tx_complete
//   pulses. It then compares outputs and the logged writes against
//   hand-computed values.
module tb_uart_tx_fifo;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        push;
   logic [7:0]  push_data;
   logic        ovf_clr;
   logic        tx_complete;
   logic        u_wr_en;
   logic [31:0] u_addr;
   logic [31:0] u_wdata;
   logic        full;
   logic        empty;
   logic [3:0]  count;
   logic        overflow;
   logic        fifo_low;
   logic        busy;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .DEPTH      (DEPTH),
      .UDATA_ADDR (32'h0000_0000),
      .UCTR_ADDR  (32'h0000_0008),
      .CTR_START  (32'h0000_0001),
      .THRESH     (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_data   (push_data),
      .ovf_clr     (ovf_clr),
      .tx_complete (tx_complete),
      .u_wr_en     (u_wr_en),
      .u_addr      (u_addr),
      .u_wdata     (u_wdata),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .overflow    (overflow),
      .fifo_low    (fifo_low),
      .busy        (busy)
   );

   int          cyc = 0;
   int          passes = 0;
   int          checks = 0;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   int          tx_cyc[$];
   int          frames = 0;
   int          max_cnt = 0;
   int          low_viol = 0;
   int          low_rise_val = -1;
   logic        track = 1'b0;
   logic        mon_on = 1'b0;
   logic        prev_low = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (u_wr_en) begin
         wa_q.push_back(u_addr);
         wd_q.push_back(u_wdata);
         wc_q.push_back(cyc);
      end
      if (mon_on && (fifo_low !== (count <= 4'd2))) low_viol <= low_viol + 1;
      if (track) begin
         if (int'(count) > max_cnt) max_cnt <= int'(count);
         if (fifo_low && !prev_low) low_rise_val <= int'(count);
      end
      prev_low <= fifo_low;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_byte(input logic [7:0] b);
      push      = 1'b1;
      push_data = b;
      tick(1);
      push      = 1'b0;
   endtask

   task automatic wait_writes(input int n);
      int lim;
      lim = 0;
      while (wa_q.size() < n && lim < 300) begin
         tick(1);
         lim++;
      end
      if (wa_q.size() < n) check("wait_writes_timeout", wa_q.size(), n);
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      tx_cyc.delete();
      frames = 0;
   endtask

   // Answer n frames: tx_complete goes high gap cycles after each control write
   task automatic serve(input int n, input int gap);
      for (int k = 0; k < n; k++) begin
         int idx;
         int tgt;
         int lim;
         idx = frames * 2 + 1;
         wait_writes(idx + 1);
         tgt = (wc_q.size() > idx) ? wc_q[idx] + gap : cyc;
         lim = 0;
         while (cyc < tgt && lim < 100) begin
            tick(1);
            lim++;
         end
         tx_complete = 1'b1;
         tx_cyc.push_back(cyc);
         tick(1);
         tx_complete = 1'b0;
         frames++;
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_empty"},    empty,    1);
      check({tag, "_count"},    count,    0);
      check({tag, "_full"},     full,     0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_fifo_low"}, fifo_low, 1);
      check({tag, "_busy"},     busy,     0);
      check({tag, "_wr_en"},    u_wr_en,  0);
      check({tag, "_addr"},     u_addr,   0);
      check({tag, "_wdata"},    u_wdata,  0);
   endtask

   initial begin
      int n0;
      int nw;
      logic [7:0] exp_b;

      rst         = 1'b1;
      push        = 1'b0;
      push_data   = 8'h00;
      ovf_clr     = 1'b0;
      tx_complete = 1'b0;

      // 1: reset held for two cycles
      tick(2);
      rst = 1'b0;
      check_reset_state("t1");
      mon_on = 1'b1;

      // 2: single byte, latency N+2 / N+3, wait for tx_complete
      n0 = cyc;
      push_byte(8'h55);
      check("t2_count_after_push", count, 1);
      check("t2_no_write_n1", u_wr_en, 0);
      tick(1);
      check("t2_data_wr_en", u_wr_en, 1);
      check("t2_data_addr", u_addr, 32'h0);
      check("t2_data_wdata", u_wdata, 32'h55);
      check("t2_busy", busy, 1);
      tick(1);
      check("t2_ctrl_wr_en", u_wr_en, 1);
      check("t2_ctrl_addr", u_addr, 32'h8);
      check("t2_ctrl_wdata", u_wdata, 32'h1);
      check("t2_empty_after_pop", empty, 1);
      tick(6);
      check("t2_wait_no_wr", u_wr_en, 0);
      check("t2_write_total", wa_q.size(), 2);
      check("t2_addr_hold", u_addr, 32'h8);
      check("t2_busy_wait", busy, 1);
      check("t2_data_cycle", wc_q[0], n0 + 2);
      check("t2_ctrl_cycle", wc_q[1], n0 + 3);
      tx_complete = 1'b1;
      tick(1);
      tx_complete = 1'b0;
      check("t2_busy_falls", busy, 0);

      // 3: eight bytes back-to-back, answered 10 cycles after each ctrl write
      clear_log();
      max_cnt = 0;
      track   = 1'b1;
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      serve(8, 10);
      track = 1'b0;
      tick(2);
      check("t3_count_peak", max_cnt, 7);
      check("t3_fifo_low_rise_at", low_rise_val, 2);
      for (int i = 0; i < 8; i++) begin
         check("t3_data_byte", wd_q[2*i], i + 1);
         check("t3_data_addr", wa_q[2*i], 32'h0);
      end
      check("t3_back_to_back", wc_q[2], tx_cyc[0] + 2);
      check("t3_drained_empty", empty, 1);
      check("t3_drained_idle", busy, 0);

      // 4: fill with the UART stalled, overflow and its clear
      clear_log();
      for (int i = 0; i < 9; i++) push_byte(8'hA0 + 8'(i));
      check("t4_full", full, 1);
      check("t4_count_full", count, 8);
      check("t4_no_ovf_yet", overflow, 0);
      push_byte(8'hA9);
      check("t4_overflow_set", overflow, 1);
      check("t4_count_after_drop", count, 8);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      check("t4_overflow_clr", overflow, 0);
      push      = 1'b1;
      push_data = 8'hEE;
      ovf_clr   = 1'b1;
      tick(1);
      push      = 1'b0;
      ovf_clr   = 1'b0;
      check("t4_set_wins", overflow, 1);
      check("t4_count_still_full", count, 8);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      check("t4_overflow_clr2", overflow, 0);

      // 5: push in the same cycle as the WR_DATA pop while full
      tx_complete = 1'b1;
      tick(1);
      tx_complete = 1'b0;
      frames = 1;
      tick(1);
      check("t5_wr_data_cycle", u_wr_en, 1);
      check("t5_wr_data_addr", u_addr, 32'h0);
      check("t5_wr_data_byte", u_wdata, 32'hA1);
      check("t5_count_before", count, 8);
      push_byte(8'hB0);
      check("t5_count_stays", count, 8);
      check("t5_no_overflow", overflow, 0);
      check("t5_full", full, 1);
      serve(9, 3);
      tick(2);
      check("t4_write_total", wa_q.size(), 20);
      for (int k = 0; k < 10; k++) begin
         exp_b = (k < 9) ? 8'hA0 + 8'(k) : 8'hB0;
         check("t4_drain_order", wd_q[2*k], {24'h0, exp_b});
      end
      check("t5_drained_empty", empty, 1);

      // 6: reset during WAIT_DONE with three bytes queued
      clear_log();
      for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
      check("t6_pre_busy", busy, 1);
      check("t6_pre_count", count, 3);
      check("t6_pre_wait", u_wr_en, 0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_reset_state("t6");
      nw = wa_q.size();
      tick(4);
      tx_complete = 1'b1;
      tick(1);
      tx_complete = 1'b0;
      tick(5);
      check("t6_no_write_after_rst", wa_q.size(), nw);
      check("t6_stray_tx_idle", busy, 0);
      push_byte(8'h77);
      wait_writes(nw + 2);
      check("t6_new_data", wd_q[nw], 32'h77);
      check("t6_new_ctrl_addr", wa_q[nw + 1], 32'h8);
      frames = nw / 2;
      serve(1, 2);
      tick(2);
      check("t6_final_idle", busy, 0);
      check("fifo_low_tracks_count", low_viol, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
